// File: rtl/control_unit.sv
// control_unit: multi-cycle instruction sequencer for a 5-bit-opcode datapath.
// Walks fetch (T0-T2) then an opcode-specific execute sequence (T3..T7).
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic [4:0]  alu_control,
  output logic        Pout,
  output logic        MDROut,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        Rout,
  output logic        BAout,
  output logic        MARen,
  output logic        MDRen,
  output logic        IRen,
  output logic        Yen,
  output logic        Pen,
  output logic        ZLOen,
  output logic        ZHIen,
  output logic        HIen,
  output logic        LOen,
  output logic        Rin,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        ConIn,
  output logic        IncPC,
  output logic        Run
);
  typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  state_t state, next;
  logic [4:0] op, cur;
  logic [2:0] last;
  logic at_end;
  logic ir_unused;
  logic s0, s1, s2, s3, s4, s5, s6, s7;
  logic is_ld, is_ldi, is_st, is_ldx, is_reg, is_imm, is_md, is_un, is_br, is_jr, is_mfhi, is_mflo;
  assign ir_unused = ^ir[26:0];
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state <= RESET;
      op    <= '0;
    end else begin
      state <= next;
      if (state == T2) op <= ir[31:27];
    end
  // In T2 the opcode is not latched yet, so the end-of-fetch decision reads ir directly.
  always_comb begin
    cur    = (state == T2) ? ir[31:27] : op;
    last   = (cur == 5'd0 || cur == 5'd2) ? 3'd7 :
             (cur == 5'd1 || (cur >= 5'd3 && cur <= 5'd14)) ? 3'd5 :
             (cur == 5'd15 || cur == 5'd16 || cur == 5'd19) ? 3'd6 :
             (cur == 5'd17 || cur == 5'd18) ? 3'd4 :
             (cur == 5'd20 || cur == 5'd24 || cur == 5'd25) ? 3'd3 : 3'd2;
    at_end = state == state_t'({1'b0, last} + 4'd1);
    next   = (state == RESET) ? T0 :
             (state == HALT) ? HALT :
             at_end ? ((stop || cur == 5'd27) ? HALT : T0) :
             state_t'(state + 4'd1);
  end
  always_comb begin
    s0 = state == T0;
    s1 = state == T1;
    s2 = state == T2;
    s3 = state == T3;
    s4 = state == T4;
    s5 = state == T5;
    s6 = state == T6;
    s7 = state == T7;
    is_ld   = op == 5'd0;
    is_ldi  = op == 5'd1;
    is_st   = op == 5'd2;
    is_ldx  = op <= 5'd2;
    is_reg  = op >= 5'd3 && op <= 5'd11;
    is_imm  = op >= 5'd12 && op <= 5'd14;
    is_md   = op == 5'd15 || op == 5'd16;
    is_un   = op == 5'd17 || op == 5'd18;
    is_br   = op == 5'd19;
    is_jr   = op == 5'd20;
    is_mfhi = op == 5'd24;
    is_mflo = op == 5'd25;
  end
  always_comb begin
    Run         = state != RESET && state != HALT;
    Pout        = s0 | (s4 & is_br);
    MARen       = s0 | (s5 & (is_ld | is_st));
    IncPC       = s0;
    ZLOen       = s0 | (s4 & (is_ldx | is_reg | is_imm | is_md)) | (s3 & is_un) | (s5 & is_br);
    ZLOout      = s1 | (s5 & (is_ldx | is_reg | is_imm | is_md)) | (s4 & is_un) | (s6 & is_br);
    Pen         = s1 | (s6 & is_br & con_ff) | (s3 & is_jr);
    Read        = s1 | (s6 & is_ld);
    MDRen       = s1 | (s6 & (is_ld | is_st));
    MDROut      = s2 | (s7 & is_ld);
    IRen        = s2;
    Grb         = (s3 & (is_ldx | is_reg | is_imm | is_un)) | (s4 & is_md);
    BAout       = s3 & is_ldx;
    Yen         = (s3 & (is_ldx | is_reg | is_imm | is_md)) | (s4 & is_br);
    Cout        = (s4 & (is_ldx | is_imm)) | (s5 & is_br);
    Gra         = (s7 & is_ld) | (s5 & (is_ldi | is_reg | is_imm)) | (s6 & is_st) |
                  (s3 & (is_md | is_br | is_jr | is_mfhi | is_mflo)) | (s4 & is_un);
    Rin         = (s7 & is_ld) | (s5 & (is_ldi | is_reg | is_imm)) | (s4 & is_un) | (s3 & (is_mfhi | is_mflo));
    Rout        = (s6 & is_st) | (s3 & (is_reg | is_imm | is_md | is_un | is_br | is_jr)) | (s4 & (is_reg | is_md));
    Grc         = s4 & is_reg;
    Write       = s7 & is_st;
    ZHIen       = s4 & is_md;
    LOen        = s5 & is_md;
    ZHIout      = s6 & is_md;
    HIen        = s6 & is_md;
    ConIn       = s3 & is_br;
    HIout       = s3 & is_mfhi;
    LOout       = s3 & is_mflo;
    alu_control = ((s4 & is_ldx) | (s5 & is_br)) ? 5'd3 :
                  ((s4 & (is_reg | is_imm | is_md)) | (s3 & is_un)) ? op : 5'd0;
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction streams checked against a step-table model.
module tb_control_unit;
  logic clk = 0, clr = 1, con_ff = 0, stop = 0;
  logic [31:0] ir = 0;
  logic [4:0] alu_control;
  logic Pout, MDROut, ZLOout, ZHIout, HIout, LOout, Cout, Rout, BAout;
  logic MARen, MDRen, IRen, Yen, Pen, ZLOen, ZHIen, HIen, LOen, Rin;
  logic Read, Write, Gra, Grb, Grc, ConIn, IncPC, Run;
  int checks = 0, failures = 0;

  localparam int POUT = 0, MDROUT = 1, ZLOOUT = 2, ZHIOUT = 3, HIOUT = 4, LOOUT = 5, COUT = 6,
                 ROUT = 7, BAOUT = 8, MAREN = 9, MDREN = 10, IREN = 11, YEN = 12, PEN = 13,
                 ZLOEN = 14, ZHIEN = 15, HIEN = 16, LOEN = 17, RIN = 18, READ = 19, WRITE = 20,
                 GRA = 21, GRB = 22, GRC = 23, CONIN = 24, INCPC = 25, RUN = 26;

  logic [31:0] obs;
  assign obs = {alu_control, Run, IncPC, ConIn, Grc, Grb, Gra, Write, Read, Rin, LOen, HIen, ZHIen,
                ZLOen, Pen, Yen, IRen, MDRen, MARen, BAout, Rout, Cout, LOout, HIout, ZHIout,
                ZLOout, MDROut, Pout};

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop), .alu_control(alu_control),
    .Pout(Pout), .MDROut(MDROut), .ZLOout(ZLOout), .ZHIout(ZHIout), .HIout(HIout), .LOout(LOout),
    .Cout(Cout), .Rout(Rout), .BAout(BAout), .MARen(MARen), .MDRen(MDRen), .IRen(IRen), .Yen(Yen),
    .Pen(Pen), .ZLOen(ZLOen), .ZHIen(ZHIen), .HIen(HIen), .LOen(LOen), .Rin(Rin), .Read(Read),
    .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .ConIn(ConIn), .IncPC(IncPC), .Run(Run)
  );

  always #5 clk = ~clk;

  function automatic int last_step(input logic [4:0] op);
    if (op == 0 || op == 2) return 7;
    if (op == 1 || (op >= 3 && op <= 14)) return 5;
    if (op == 15 || op == 16 || op == 19) return 6;
    if (op == 17 || op == 18) return 4;
    if (op == 20 || op == 24 || op == 25) return 3;
    return 2;
  endfunction

  // Expected {alu_control, signals} for a given instruction step, straight from the step lists.
  function automatic logic [31:0] model(input logic [4:0] op, input int step, input logic cf);
    logic [26:0] s;
    logic [4:0] a;
    s = '0;
    a = '0;
    s[RUN] = 1'b1;
    if (step == 0) begin
      s[POUT] = 1; s[MAREN] = 1; s[INCPC] = 1; s[ZLOEN] = 1;
    end else if (step == 1) begin
      s[ZLOOUT] = 1; s[PEN] = 1; s[READ] = 1; s[MDREN] = 1;
    end else if (step == 2) begin
      s[MDROUT] = 1; s[IREN] = 1;
    end else if (op <= 2) begin
      if (step == 3) begin s[GRB] = 1; s[BAOUT] = 1; s[YEN] = 1; end
      if (step == 4) begin s[COUT] = 1; a = 5'd3; s[ZLOEN] = 1; end
      if (step == 5 && op == 1) begin s[ZLOOUT] = 1; s[GRA] = 1; s[RIN] = 1; end
      if (step == 5 && op != 1) begin s[ZLOOUT] = 1; s[MAREN] = 1; end
      if (step == 6 && op == 0) begin s[READ] = 1; s[MDREN] = 1; end
      if (step == 6 && op == 2) begin s[GRA] = 1; s[ROUT] = 1; s[MDREN] = 1; end
      if (step == 7 && op == 0) begin s[MDROUT] = 1; s[GRA] = 1; s[RIN] = 1; end
      if (step == 7 && op == 2) s[WRITE] = 1;
    end else if (op <= 14) begin
      if (step == 3) begin s[GRB] = 1; s[ROUT] = 1; s[YEN] = 1; end
      if (step == 4) begin
        if (op <= 11) begin s[GRC] = 1; s[ROUT] = 1; end else s[COUT] = 1;
        a = op; s[ZLOEN] = 1;
      end
      if (step == 5) begin s[ZLOOUT] = 1; s[GRA] = 1; s[RIN] = 1; end
    end else if (op <= 16) begin
      if (step == 3) begin s[GRA] = 1; s[ROUT] = 1; s[YEN] = 1; end
      if (step == 4) begin s[GRB] = 1; s[ROUT] = 1; a = op; s[ZLOEN] = 1; s[ZHIEN] = 1; end
      if (step == 5) begin s[ZLOOUT] = 1; s[LOEN] = 1; end
      if (step == 6) begin s[ZHIOUT] = 1; s[HIEN] = 1; end
    end else if (op <= 18) begin
      if (step == 3) begin s[GRB] = 1; s[ROUT] = 1; a = op; s[ZLOEN] = 1; end
      if (step == 4) begin s[ZLOOUT] = 1; s[GRA] = 1; s[RIN] = 1; end
    end else if (op == 19) begin
      if (step == 3) begin s[GRA] = 1; s[ROUT] = 1; s[CONIN] = 1; end
      if (step == 4) begin s[POUT] = 1; s[YEN] = 1; end
      if (step == 5) begin s[COUT] = 1; a = 5'd3; s[ZLOEN] = 1; end
      if (step == 6) begin s[ZLOOUT] = 1; s[PEN] = cf; end
    end else if (op == 20) begin
      s[GRA] = 1; s[ROUT] = 1; s[PEN] = 1;
    end else if (op == 24) begin
      s[HIOUT] = 1; s[GRA] = 1; s[RIN] = 1;
    end else if (op == 25) begin
      s[LOOUT] = 1; s[GRA] = 1; s[RIN] = 1;
    end
    return {a, s};
  endfunction

  // Starts in T0 at a falling edge; ends in T0 (or HALT) at a falling edge. cf_mode<0 randomizes con_ff.
  task automatic run_instr(input logic [31:0] i, input logic s, input int cf_mode, input string name);
    logic [4:0] op;
    logic [31:0] exp;
    int last;
    op = i[31:27];
    last = last_step(op);
    ir = i;
    stop = s;
    for (int st = 0; st <= last; st++) begin
      if (st > 0) @(negedge clk);
      con_ff = (cf_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(cf_mode);
      #1;
      exp = model(op, st, con_ff);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s op=%0d T%0d: got %h want %h", name, op, st, obs, exp);
      end
    end
    @(negedge clk);
    #1;
    exp = (s || op == 5'd27) ? 32'h0 : model(op, 0, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s op=%0d after_end: got %h want %h", name, op, obs, exp);
    end
    stop = 0;
  endtask

  task automatic test_reset();
    #1 clr = 0;
    #1;
    checks++;
    if (obs !== 32'h0) begin failures++; $display("FAIL reset_async: got %h want 0", obs); end
    @(negedge clk);
    checks++;
    if (obs !== 32'h0) begin failures++; $display("FAIL reset_hold: got %h want 0", obs); end
    clr = 1;
    @(negedge clk);
    checks++;
    if (obs !== model(5'd0, 0, 1'b0) || Run !== 1'b1) begin
      failures++;
      $display("FAIL first_t0: got %h want %h", obs, model(5'd0, 0, 1'b0));
    end
  endtask

  task automatic do_reset(input string name);
    clr = 0;
    #1;
    checks++;
    if (obs !== 32'h0) begin failures++; $display("FAIL %s clr_async: got %h want 0", name, obs); end
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    checks++;
    if (obs !== model(5'd0, 0, 1'b0)) begin
      failures++;
      $display("FAIL %s restart_t0: got %h want %h", name, obs, model(5'd0, 0, 1'b0));
    end
  endtask

  task automatic test_st();
    run_instr(32'h1088_0000, 1'b0, -1, "st");
  endtask

  task automatic test_add();
    run_instr({5'd3, 27'($urandom)}, 1'b0, -1, "add");
  endtask

  task automatic test_br();
    run_instr({5'd19, 27'($urandom)}, 1'b0, 0, "br_cf0");
    run_instr({5'd19, 27'($urandom)}, 1'b0, 1, "br_cf1");
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int n = 0; n < 60; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      run_instr({op, 27'($urandom)}, 1'b0, -1, "random");
    end
  endtask

  task automatic test_clr_mid();
    logic [31:0] exp;
    ir = {5'd0, 27'($urandom)};
    for (int st = 0; st <= 6; st++) begin
      if (st > 0) @(negedge clk);
      con_ff = 1'($urandom_range(0, 1));
      #1;
      exp = model(5'd0, st, con_ff);
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL clr_mid T%0d: got %h want %h", st, obs, exp); end
    end
    clr = 0;
    #1;
    checks++;
    if (obs !== 32'h0) begin failures++; $display("FAIL clr_mid_async: got %h want 0", obs); end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 32'h0 || Rin !== 1'b0) begin failures++; $display("FAIL clr_mid_held: got %h want 0", obs); end
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    checks++;
    if (obs !== model(5'd0, 0, 1'b0)) begin
      failures++;
      $display("FAIL clr_mid_restart: got %h want %h", obs, model(5'd0, 0, 1'b0));
    end
    run_instr({5'd26, 27'($urandom)}, 1'b0, -1, "post_clr_nop");
  endtask

  task automatic test_halt();
    run_instr({5'd27, 27'($urandom)}, 1'b0, -1, "halt");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      con_ff = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (obs !== 32'h0) begin failures++; $display("FAIL halt_hold c%0d: got %h want 0", c, obs); end
    end
    do_reset("halt");
  endtask

  task automatic test_stop();
    run_instr({5'd3, 27'($urandom)}, 1'b1, -1, "stop_add");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (obs !== 32'h0) begin failures++; $display("FAIL stop_hold c%0d: got %h want 0", c, obs); end
    end
    do_reset("stop_add");
    run_instr({5'd26, 27'($urandom)}, 1'b1, -1, "stop_nop");
    do_reset("stop_nop");
  endtask

  initial begin
    test_reset();
    test_st();
    test_add();
    test_br();
    test_random();
    test_clr_mid();
    test_halt();
    test_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
